regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter.sv | 139 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among four requesters, with bounded locked bursts.
// Define REGFILE_R0_ZERO_EN to consume transfers aimed at register 0 without ever writing it.
module regfile_write_arbiter #(
    parameter int WIDTH     = 16,
    parameter int ADDR      = 4,
    parameter int MAX_BURST = 8
) (
    input  logic             C,
    input  logic             RST,
    input  logic [3:0]       REQ,
    input  logic [3:0]       LOCK,
    input  logic [WIDTH-1:0] DATA0,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [WIDTH-1:0] DATA3,
    input  logic [ADDR-1:0]  DEST0,
    input  logic [ADDR-1:0]  DEST1,
    input  logic [ADDR-1:0]  DEST2,
    input  logic [ADDR-1:0]  DEST3,
    output logic [3:0]       GNT,
    output logic [WIDTH-1:0] D,
    output logic [ADDR-1:0]  DEST_SEL,
    output logic             LOAD_EN,
    output logic             BUSY
);

    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

    state_t           state;
    state_t           next_state;
    logic [1:0]       ptr;
    logic [1:0]       next_ptr;
    logic [1:0]       owner;
    logic [1:0]       arb_ptr;
    logic [1:0]       winner;
    logic             has_winner;
    logic             hold;
    logic [3:0]       burst_cnt;
    logic [3:0]       next_cnt;
    logic [3:0]       next_gnt;
    logic             transfer;
    logic             write_en;
    logic [WIDTH-1:0] wr_data;
    logic [ADDR-1:0]  wr_dest;
    logic [WIDTH-1:0] data_arr [4];
    logic [ADDR-1:0]  dest_arr [4];

    assign data_arr[0] = DATA0;
    assign data_arr[1] = DATA1;
    assign data_arr[2] = DATA2;
    assign data_arr[3] = DATA3;
    assign dest_arr[0] = DEST0;
    assign dest_arr[1] = DEST1;
    assign dest_arr[2] = DEST2;
    assign dest_arr[3] = DEST3;

    // GNT is one-hot whenever a grant is live, so the owner is a plain encode of it.
    assign owner    = {GNT[3] | GNT[2], GNT[3] | GNT[1]};
    assign transfer = |(REQ & GNT);
    assign arb_ptr  = (state == IDLE) ? ptr : owner + 2'd1;

    // Scan from the highest offset down so the requester closest to arb_ptr wins.
    always_comb begin
        has_winner = 1'b0;
        winner     = arb_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (REQ[arb_ptr + 2'(k)]) begin
                has_winner = 1'b1;
                winner     = arb_ptr + 2'(k);
            end
        end
    end

    always_ff @(posedge C or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            GNT       <= 4'b0000;
            ptr       <= 2'd0;
            burst_cnt <= 4'd0;
            BUSY      <= 1'b0;
        end else begin
            state     <= next_state;
            GNT       <= next_gnt;
            ptr       <= next_ptr;
            burst_cnt <= next_cnt;
            BUSY      <= (next_state == LOCKED);
        end
    end

    // A burst continues only while the owner keeps REQ and LOCK and has words left under the limit.
    always_comb begin
        next_state = state;
        next_gnt   = GNT;
        next_ptr   = ptr;
        next_cnt   = burst_cnt;
        hold       = (state == LOCKED) && REQ[owner] && LOCK[owner]
                     && ((burst_cnt + 4'd1) != 4'(MAX_BURST));
        if (hold) begin
            next_cnt = burst_cnt + 4'd1;
        end else begin
            next_cnt = 4'd0;
            if (state != IDLE) begin
                next_ptr = owner + 2'd1;
            end
            if (has_winner) begin
                next_gnt   = 4'b0001 << winner;
                next_state = LOCK[winner] ? LOCKED : GRANT;
            end else begin
                next_gnt   = 4'b0000;
                next_state = IDLE;
            end
        end
    end

    always_comb begin
        wr_data = data_arr[owner];
        wr_dest = dest_arr[owner];
`ifdef REGFILE_R0_ZERO_EN
        write_en = transfer && (dest_arr[owner] != '0);
`else
        write_en = transfer;
`endif
    end

    always_ff @(posedge C or posedge RST) begin
        if (RST) begin
            D        <= '0;
            DEST_SEL <= '0;
            LOAD_EN  <= 1'b0;
        end else begin
            LOAD_EN <= write_en;
            if (write_en) begin
                D        <= wr_data;
                DEST_SEL <= wr_dest;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_regfile_write_arbiter;

    localparam int WIDTH     = 16;
    localparam int ADDR      = 4;
    localparam int MAX_BURST = 8;

    logic             c = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       req = 4'b0000;
    logic [3:0]       lock = 4'b0000;
    logic [WIDTH-1:0] data [4];
    logic [ADDR-1:0]  dest [4];
    logic [3:0]       GNT;
    logic [WIDTH-1:0] D;
    logic [ADDR-1:0]  DEST_SEL;
    logic             LOAD_EN;
    logic             BUSY;

    int total = 0;
    int bad = 0;

    int               m_ptr;
    int               m_owner;
    int               m_cnt;
    bit               m_locked;
    logic [3:0]       m_gnt;
    logic             m_busy;
    logic             m_load;
    logic [WIDTH-1:0] m_d;
    logic [ADDR-1:0]  m_dest;

    regfile_write_arbiter #(
        .WIDTH(WIDTH), .ADDR(ADDR), .MAX_BURST(MAX_BURST)
    ) dut (
        .C(c), .RST(rst), .REQ(req), .LOCK(lock),
        .DATA0(data[0]), .DATA1(data[1]), .DATA2(data[2]), .DATA3(data[3]),
        .DEST0(dest[0]), .DEST1(dest[1]), .DEST2(dest[2]), .DEST3(dest[3]),
        .GNT(GNT), .D(D), .DEST_SEL(DEST_SEL), .LOAD_EN(LOAD_EN), .BUSY(BUSY)
    );

    always #5 c = ~c;

    task automatic model_reset();
        m_ptr    = 0;
        m_owner  = -1;
        m_cnt    = 0;
        m_locked = 0;
        m_gnt    = 4'b0000;
        m_busy   = 1'b0;
        m_load   = 1'b0;
        m_d      = '0;
        m_dest   = '0;
    endtask

    // Owner is a requester number (or -1); the model decides what happens at the coming edge.
    task automatic model_step();
        int  o;
        int  start;
        bit  xfer;
        bit  writes;
        o    = m_owner;
        xfer = (o >= 0) && req[o];
        writes = xfer;
`ifdef REGFILE_R0_ZERO_EN
        if (xfer && dest[o] == 0) writes = 0;
`endif
        m_load = writes;
        if (writes) begin
            m_d    = data[o];
            m_dest = dest[o];
        end
        if (m_locked && req[o] && lock[o] && (m_cnt + 1 < MAX_BURST)) begin
            m_cnt = m_cnt + 1;
        end else begin
            start = (o >= 0) ? (o + 1) % 4 : m_ptr;
            if (o >= 0) m_ptr = start;
            m_cnt    = 0;
            m_owner  = -1;
            m_locked = 0;
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && req[(start + k) % 4]) m_owner = (start + k) % 4;
            end
            if (m_owner >= 0) m_locked = lock[m_owner];
        end
        m_gnt  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        m_busy = m_locked;
    endtask

    task automatic cycle();
        model_step();
        @(posedge c);
        #1;
    endtask

    task automatic apply_reset();
        req  = 4'b0000;
        lock = 4'b0000;
        rst  = 1'b1;
        #2;
        rst  = 1'b0;
        model_reset();
        cycle();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            data[i] = 16'h1100 + 16'(i);
            dest[i] = 4'(i + 1);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (GNT !== 4'b0000 || LOAD_EN !== 1'b0 || D !== 16'h0 || DEST_SEL !== 4'h0 || BUSY !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_initial got gnt=%b load=%b d=%h dest=%h busy=%b expected all zero",
                     GNT, LOAD_EN, D, DEST_SEL, BUSY);
        end
        @(posedge c);
        #1 rst = 1'b0;
        model_reset();
        req = 4'b1111;
        cycle();
        cycle();
        total++;
        if (LOAD_EN !== 1'b1 || GNT !== 4'b0010) begin
            bad++;
            $display("[TB] FAIL reset_pre_active got load=%b gnt=%b expected load=1 gnt=0010", LOAD_EN, GNT);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (GNT !== 4'b0000 || LOAD_EN !== 1'b0 || D !== 16'h0 || DEST_SEL !== 4'h0 || BUSY !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_midcycle got gnt=%b load=%b d=%h dest=%h busy=%b expected all zero",
                     GNT, LOAD_EN, D, DEST_SEL, BUSY);
        end
        req = 4'b0000;
        @(posedge c);
        #1 rst = 1'b0;
        model_reset();
        req = 4'b1000;
        cycle();
        total++;
        if (GNT !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL reset_regrant got gnt=%b expected 1000", GNT);
        end
        req = 4'b0000;
        cycle();
        cycle();
    endtask

    task automatic test_single_write();
        apply_reset();
        data[2] = 16'hBEEF;
        dest[2] = 4'd5;
        req = 4'b0100;
        cycle();
        total++;
        if (GNT !== 4'b0100 || LOAD_EN !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_grant got gnt=%b load=%b expected gnt=0100 load=0", GNT, LOAD_EN);
        end
        cycle();
        req = 4'b0000;
        total++;
        if (LOAD_EN !== 1'b1 || D !== 16'hBEEF || DEST_SEL !== 4'd5) begin
            bad++;
            $display("[TB] FAIL single_write got load=%b d=%h dest=%0d expected load=1 d=beef dest=5",
                     LOAD_EN, D, DEST_SEL);
        end
        cycle();
        total++;
        if (LOAD_EN !== 1'b0 || GNT !== 4'b0000 || D !== 16'hBEEF) begin
            bad++;
            $display("[TB] FAIL single_after got load=%b gnt=%b d=%h expected load=0 gnt=0000 d=beef",
                     LOAD_EN, GNT, D);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_gnt;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            data[i] = 16'hA000 + 16'(i);
            dest[i] = 4'(i + 8);
        end
        req = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            cycle();
            exp_gnt = 4'(1 << (k % 4));
            total++;
            if (GNT !== exp_gnt || LOAD_EN !== (k >= 1)) begin
                bad++;
                $display("[TB] FAIL fairness_step%0d got gnt=%b load=%b expected gnt=%b load=%b",
                         k, GNT, LOAD_EN, exp_gnt, (k >= 1));
            end
            if (k >= 1) begin
                total++;
                if (D !== 16'hA000 + 16'((k - 1) % 4)) begin
                    bad++;
                    $display("[TB] FAIL fairness_data%0d got d=%h expected %h",
                             k, D, 16'hA000 + 16'((k - 1) % 4));
                end
            end
        end
        req = 4'b0000;
        cycle();
        total++;
        if (LOAD_EN !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fairness_end got load=%b expected 0", LOAD_EN);
        end
        cycle();
    endtask

    task automatic test_lock_limit();
        logic [3:0] exp_gnt;
        logic       exp_busy;
        apply_reset();
        req  = 4'b1010;
        lock = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            cycle();
            exp_gnt  = (k == 8) ? 4'b1000 : 4'b0010;
            exp_busy = (k != 8);
            total++;
            if (GNT !== exp_gnt || BUSY !== exp_busy || LOAD_EN !== (k >= 1)) begin
                bad++;
                $display("[TB] FAIL lock_step%0d got gnt=%b busy=%b load=%b expected gnt=%b busy=%b load=%b",
                         k, GNT, BUSY, LOAD_EN, exp_gnt, exp_busy, (k >= 1));
            end
        end
        req  = 4'b0000;
        lock = 4'b0000;
        cycle();
        cycle();
    endtask

    task automatic test_wasted_grant();
        apply_reset();
        req = 4'b0001;
        cycle();
        req = 4'b0000;
        total++;
        if (GNT !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL wasted_grant got gnt=%b expected 0001", GNT);
        end
        cycle();
        total++;
        if (LOAD_EN !== 1'b0 || GNT !== 4'b0000 || BUSY !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wasted_idle got load=%b gnt=%b busy=%b expected 0 0000 0", LOAD_EN, GNT, BUSY);
        end
    endtask

    task automatic test_r0();
        logic             exp_load;
        logic [WIDTH-1:0] exp_d;
        apply_reset();
        data[0] = 16'hAAAA;
        dest[0] = 4'd0;
        req = 4'b0001;
        cycle();
        cycle();
`ifdef REGFILE_R0_ZERO_EN
        exp_load = 1'b0;
        exp_d    = 16'h0000;
`else
        exp_load = 1'b1;
        exp_d    = 16'hAAAA;
`endif
        total++;
        if (LOAD_EN !== exp_load || D !== exp_d || DEST_SEL !== 4'd0) begin
            bad++;
            $display("[TB] FAIL r0_first got load=%b d=%h dest=%0d expected load=%b d=%h dest=0",
                     LOAD_EN, D, DEST_SEL, exp_load, exp_d);
        end
        data[0] = 16'h5555;
        dest[0] = 4'd7;
        cycle();
        req = 4'b0000;
        total++;
        if (LOAD_EN !== 1'b1 || D !== 16'h5555 || DEST_SEL !== 4'd7) begin
            bad++;
            $display("[TB] FAIL r0_second got load=%b d=%h dest=%0d expected load=1 d=5555 dest=7",
                     LOAD_EN, D, DEST_SEL);
        end
        cycle();
        cycle();
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 4; i++) begin
                req[i]  = ($urandom_range(0, 3) != 0);
                data[i] = 16'($urandom);
                dest[i] = 4'($urandom);
            end
            lock = ($urandom_range(0, 3) != 0) ? 4'b1111 : 4'($urandom);
            cycle();
            total++;
            if (GNT !== m_gnt || BUSY !== m_busy || LOAD_EN !== m_load || D !== m_d || DEST_SEL !== m_dest) begin
                bad++;
                $display("[TB] FAIL random_cycle%0d got gnt=%b busy=%b load=%b d=%h dest=%h expected gnt=%b busy=%b load=%b d=%h dest=%h",
                         n, GNT, BUSY, LOAD_EN, D, DEST_SEL, m_gnt, m_busy, m_load, m_d, m_dest);
            end
        end
        req  = 4'b0000;
        lock = 4'b0000;
        cycle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_write();
        test_fairness();
        test_lock_limit();
        test_wasted_grant();
        test_r0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
